// File: rtl/ram_responder.sv
// Byte-wide single-port RAM responder with a memory-mapped TX FIFO in the I/O window.
// Optional feature: define RAM_IO_STATUS_EN for the sticky overflow flag and the status register.
module ram_responder #(
    parameter int unsigned ADDR_BITS  = 17,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_ram_rd_wt_flag,
    input  logic [31:0] in_ram_addr,
    input  logic [7:0]  in_ram_data,
    output logic [7:0]  out_ram_data,
    output logic        out_io_valid,
    output logic [7:0]  out_io_data,
    input  logic        in_io_ready
);

    localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned MemSize = 1 << ADDR_BITS;
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
    localparam logic [15:0] OffTx     = 16'h0000;
    localparam logic [15:0] OffStatus = 16'h0004;

    logic [7:0] mem [MemSize];

    // Address decode
    logic                 is_io;
    logic [15:0]          io_off;
    logic [ADDR_BITS-1:0] ram_idx;
    logic                 ram_we;
    logic                 io_we;
    logic                 unused_addr;

    assign is_io       = (in_ram_addr[17:16] == 2'b11);
    assign io_off      = in_ram_addr[15:0];
    assign ram_idx     = in_ram_addr[ADDR_BITS-1:0];
    assign ram_we      = in_ram_rd_wt_flag && !is_io;
    assign io_we       = in_ram_rd_wt_flag && is_io;
    assign unused_addr = ^in_ram_addr[31:18];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= in_ram_data;
        end
    end

    // TX FIFO
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            full;
    logic            push_req;
    logic            push;
    logic            pop;

    assign out_io_valid = (cnt_q != '0);
    assign full         = (cnt_q == CntFull);
    assign push_req     = io_we && (io_off == OffTx);
    assign pop          = out_io_valid && in_io_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push         = push_req && (!full || pop);
    assign out_io_data  = out_io_valid ? fifo_mem[rd_ptr_q] : 8'h00;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_ram_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Status and overflow
    logic [7:0] status_byte;

`ifdef RAM_IO_STATUS_EN
    logic ovf_q, ovf_d;
    logic drop;
    logic clr_ovf;

    assign drop        = push_req && full && !pop;
    assign clr_ovf     = io_we && (io_off == OffStatus);
    assign ovf_d       = clr_ovf ? 1'b0 : (drop ? 1'b1 : ovf_q);
    assign status_byte = {5'b0, ovf_q, out_io_valid, full};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`else
    assign status_byte = 8'h00;
`endif

    // Read data path
    logic [31:0] cnt_ext;
    logic [7:0]  cnt_byte;
    logic [7:0]  io_rdata;
    logic [7:0]  rdata_q, rdata_d;

    assign cnt_ext  = 32'(cnt_q);
    assign cnt_byte = (cnt_ext > 32'd255) ? 8'hFF : cnt_ext[7:0];

    always_comb begin
        io_rdata = 8'h00;
        if (io_off == OffTx) begin
            io_rdata = cnt_byte;
        end else if (io_off == OffStatus) begin
            io_rdata = status_byte;
        end
        rdata_d = is_io ? io_rdata : mem[ram_idx];
    end

    assign out_ram_data = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q  <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rdata_q  <= rdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed plan steps then random traffic vs a queue model.
module tb_ram_responder;

    localparam int Depth = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flag = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [7:0]  wdata = 8'h00;
    logic        io_ready = 1'b0;
    logic [7:0]  rdata;
    logic        io_valid;
    logic [7:0]  io_data;

    always #5 clk = ~clk;

    ram_responder dut (
        .clk              (clk),
        .rst              (rst),
        .in_ram_rd_wt_flag(flag),
        .in_ram_addr      (addr),
        .in_ram_data      (wdata),
        .out_ram_data     (rdata),
        .out_io_valid     (io_valid),
        .out_io_data      (io_data),
        .in_io_ready      (io_ready)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: sparse RAM image, FIFO as a queue, overflow bit.
    bit [7:0] ram_m [int];
    bit [7:0] fifo_m [$];
    bit       ovf_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, clock, update model, compare every output.
    task automatic cyc(input logic wr, input logic [31:0] a, input logic [7:0] d, input logic rdy);
        bit       io;
        int       off;
        int       idx;
        int       n;
        bit       full0;
        bit       pop;
        bit       known;
        bit [7:0] exp_rd;
        flag = wr;
        addr = a;
        wdata = d;
        io_ready = rdy;
        io = (a[17:16] == 2'b11);
        off = int'(a[15:0]);
        idx = int'(a & 32'h0001_FFFF);
        n = fifo_m.size();
        full0 = (n == Depth);
        pop = (n > 0) && rdy;
        known = 1'b1;
        exp_rd = 8'h00;
        if (io) begin
            if (off == 0) exp_rd = 8'(n);
`ifdef RAM_IO_STATUS_EN
            else if (off == 4) exp_rd = {5'b0, ovf_m, n != 0, full0};
`endif
        end else if (ram_m.exists(idx)) begin
            exp_rd = ram_m[idx];
        end else begin
            known = 1'b0;
        end
        @(posedge clk);
        #1;
        if (wr && !io) ram_m[idx] = d;
        if (pop) void'(fifo_m.pop_front());
        if (wr && io && off == 0) begin
            if (!full0 || pop) fifo_m.push_back(d);
            else ovf_m = 1'b1;
        end
        if (wr && io && off == 4) ovf_m = 1'b0;
        if (known) check("rd_data", rdata, exp_rd);
        check("io_valid", io_valid, fifo_m.size() != 0);
        check("io_data", io_data, (fifo_m.size() != 0) ? fifo_m[0] : 8'h00);
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b0;
        #1;
        check("rst_rdata", rdata, 8'h00);
        check("rst_valid", io_valid, 1'b0);
        check("rst_iodata", io_data, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;

        // Write then read back
        cyc(1'b1, 32'h0001_0, 8'hA5, 1'b0);
        cyc(1'b0, 32'h0001_0, 8'h00, 1'b0);
        check("wr_rd", rdata, 8'hA5);

        // Upper address bits alias
        cyc(1'b1, 32'h0000_0020, 8'h3C, 1'b0);
        cyc(1'b1, 32'h0002_0020, 8'h5A, 1'b0);
        cyc(1'b0, 32'h0000_0020, 8'h00, 1'b0);
        check("alias", rdata, 8'h5A);
        cyc(1'b1, 32'h0000_0100, 8'h77, 1'b0);

        // Three TX bytes, count, in-order drain
        cyc(1'b1, 32'h0003_0000, 8'h41, 1'b0);
        cyc(1'b1, 32'h0003_0000, 8'h42, 1'b0);
        cyc(1'b1, 32'h0003_0000, 8'h43, 1'b0);
        check("tx_valid", io_valid, 1'b1);
        check("tx_head", io_data, 8'h41);
        cyc(1'b0, 32'h0003_0000, 8'h00, 1'b0);
        check("tx_count3", rdata, 8'd3);
        for (int i = 0; i < 3; i++) begin
            check("drain_order", io_data, 8'h41 + 8'(i));
            cyc(1'b0, 32'h0, 8'h00, 1'b1);
        end
        check("drain_empty", io_valid, 1'b0);

        // Fill, overflow drop, status
        for (int i = 0; i < Depth; i++) cyc(1'b1, 32'h0003_0000, 8'h80 + 8'(i), 1'b0);
        cyc(1'b1, 32'h0003_0000, 8'hEE, 1'b0);
        cyc(1'b0, 32'h0003_0000, 8'h00, 1'b0);
        check("full_count", rdata, 8'd16);
        cyc(1'b0, 32'h0003_0004, 8'h00, 1'b0);
`ifdef RAM_IO_STATUS_EN
        check("status_ovf", rdata, 8'h07);
`else
        check("status_ovf", rdata, 8'h00);
`endif
        check("full_head", io_data, 8'h80);

        // Full with simultaneous pop: both happen, no overflow
        cyc(1'b1, 32'h0003_0004, 8'h00, 1'b0);
        cyc(1'b1, 32'h0003_0000, 8'hD1, 1'b1);
        check("pp_head", io_data, 8'h81);
        cyc(1'b0, 32'h0003_0000, 8'h00, 1'b0);
        check("pp_count", rdata, 8'd16);
        cyc(1'b0, 32'h0003_0004, 8'h00, 1'b0);
`ifdef RAM_IO_STATUS_EN
        check("pp_status", rdata, 8'h03);
`else
        check("pp_status", rdata, 8'h00);
`endif

        // Drain to 5 queued, then reset mid-drain
        for (int i = 0; i < Depth - 5; i++) cyc(1'b0, 32'h0000_0010, 8'h00, 1'b1);
        check("pre_rst_rdata", rdata, 8'hA5);
        check("pre_rst_valid", io_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", io_valid, 1'b0);
        check("mid_rst_rdata", rdata, 8'h00);
        check("mid_rst_iodata", io_data, 8'h00);
        fifo_m.delete();
        ovf_m = 1'b0;
        flag = 1'b0;
        io_ready = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        cyc(1'b0, 32'h0000_0100, 8'h00, 1'b0);
        check("ram_kept", rdata, 8'h77);
        cyc(1'b0, 32'h0003_0000, 8'h00, 1'b0);
        check("rst_count", rdata, 8'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            int sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    a = 32'h0000_0000 + $urandom_range(0, 31);
                2:       a = 32'h0002_0000 + $urandom_range(0, 31);
                3:       a = 32'h0004_0000 + $urandom_range(0, 31);
                4:       a = 32'h0001_0000 + $urandom_range(0, 31);
                5, 6, 7: a = 32'h0003_0000;
                8:       a = 32'h0003_0004;
                default: a = (($urandom_range(0, 1) == 0) ? 32'h0007_0000 : 32'h0003_0000)
                             + 4 * $urandom_range(0, 3);
            endcase
            cyc(1'($urandom_range(0, 1)), a, 8'($urandom),
                ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
